// File: rtl/manchester_decoder_if.sv
// Line-side and word-side signals of the Manchester receiver.
// The bench or upstream logic drives en/in1 through the master modport;
// the decoder returns the decoded word and status through the slave modport.
interface manchester_decoder_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             in1;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             err;
    logic             busy;

    modport master (
        output en,
        output in1,
        input  out,
        input  out_valid,
        input  err,
        input  busy
    );

    modport slave (
        input  en,
        input  in1,
        output out,
        output out_valid,
        output err,
        output busy
    );
endinterface

// File: rtl/manchester_decoder.sv
// Oversampled Manchester (IEEE 802.3 polarity) receiver.
// Bit 1 is a low-to-high mid-bit transition, bit 0 is high-to-low.
// A frame is a '1' start bit followed by whole WIDTH-bit words, MSB first,
// then the line is held low. The decoder re-anchors its timing on every
// mid-bit edge, samples the first-half level of the next bit, and then
// waits for the opposite level to appear (the next mid-bit edge).
module manchester_decoder #(
    parameter int HALF  = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    manchester_decoder_if.slave mif
);
    localparam int CNT_W = $clog2(5 * HALF / 2 + 1);
    localparam int BC_W  = $clog2(WIDTH + 1);

    // First-half sample point and edge timeout, in cycles after the last mid-bit edge.
    localparam logic [CNT_W-1:0] CNT_SAMPLE  = CNT_W'(3 * HALF / 2);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(5 * HALF / 2);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [BC_W-1:0]  BC_LAST     = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]  BC_ONE      = BC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE_A,
        ST_EDGE_WAIT
    } state_t;

    // Synchronizer and edge history
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_s;

    // Decode state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [BC_W-1:0]  w_bit_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             r_a;
    logic             w_a_nxt;

    // Registered outputs
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;

    assign w_s       = r_sync2;
    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_shifted = {r_shift[WIDTH-2:0], w_s};

    // Two-flop synchronizer for the asynchronous line, plus the previous s for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= mif.in1;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_a         <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_a         <= w_a_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state decode: start detection, first-half sampling, mid-bit edge search and timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_a_nxt         = r_a;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;

        if (!mif.en) begin
            // Disabled: drop any partial word silently, keep the last word on out.
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A rising edge is the start bit's mid-bit transition.
                    if (w_s && !r_prev) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SAMPLE_A;
                    end
                end

                ST_SAMPLE_A: begin
                    w_cnt_nxt = w_cnt_inc;
                    // Middle of the next bit's first half: remember its level.
                    if (w_cnt_inc == CNT_SAMPLE) begin
                        w_a_nxt     = w_s;
                        w_state_nxt = ST_EDGE_WAIT;
                    end
                end

                ST_EDGE_WAIT: begin
                    if (w_s != r_a) begin
                        // Mid-bit edge: the new level is the bit value; re-anchor timing here.
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SAMPLE_A;
                        w_shift_nxt = w_shifted;
                        if (r_bit_cnt == BC_LAST) begin
                            w_out_nxt       = w_shifted;
                            w_out_valid_nxt = 1'b1;
                            w_bit_cnt_nxt   = '0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BC_ONE;
                        end
                    end else if (w_cnt_inc == CNT_TIMEOUT) begin
                        // No edge: a low line on a word boundary is a clean end of frame,
                        // anything else is a code or framing violation.
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = '0;
                        w_bit_cnt_nxt = '0;
                        w_shift_nxt   = '0;
                        if (r_bit_cnt != '0 || r_a) begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign mif.out       = r_out;
    assign mif.out_valid = r_out_valid;
    assign mif.err       = r_err;
    assign mif.busy      = (r_state != ST_IDLE);

endmodule

// File: doc/manchester_decoder.md
Name: manchester_decoder

Overview:
- Serial-line receiver. Decodes an oversampled Manchester (IEEE 802.3 convention) bit stream into WIDTH-bit words.
- Partner of the team's inverting/encoding line-driver gates. It recovers data that the transmit side encoded as mid-bit transitions.
- Sits between an asynchronous serial pin and a word-oriented consumer.
- Checks framing and code violations.

Parameters:
- HALF, 4: clk cycles per half-bit. Must be even and >= 4. Bit period = 2*HALF.
- WIDTH, 8: bits per output word, shifted in MSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  receiver enable. Low forces IDLE.
- in1  input  1  asynchronous serial line. Idle level is low.
- out  output  WIDTH  last completed word. Held until the next word completes.
- out_valid  output  1  one-cycle pulse when out is updated.
- err  output  1  one-cycle pulse on a code violation or framing error.
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (rst high at a clk edge): out=0, out_valid=0, err=0, busy=0, both sync flops=0, state=IDLE, bit_cnt=0, shift=0. Reset has priority over en and mid-frame activity; a partial word is discarded silently.
- Synchronizer: in1 passes through 2 flops; s denotes the second flop. All decoding uses s only.
- Encoding: bit 1 = low-to-high mid-bit transition; bit 0 = high-to-low.
- Frame format: start bit '1', then N*WIDTH data bits, then the line held low. Frames end only at word boundaries.
- IDLE:
  - busy=0.
  - Track the previous value of s.
  - A rising edge on s (prev=0, s=1) is taken as the start bit's mid-bit edge: cnt<=0, go to SAMPLE_A.
- SAMPLE_A:
  - cnt increments each cycle.
  - When cnt == 3*HALF/2, latch A<=s (first-half level of the next bit) and go to EDGE_WAIT.
- EDGE_WAIT:
  - cnt continues.
  - If s != A: the bit value is s, shifted into shift[0] with the rest moved left; bit_cnt++; cnt<=0 (re-anchor on the observed edge); return to SAMPLE_A.
  - If cnt reaches 5*HALF/2 with no edge, this is a violation:
    - bit_cnt==0 and A==0: normal end of frame. Go to IDLE, no err.
    - Otherwise: err pulses for 1 cycle, shift and bit_cnt are cleared, state goes to IDLE.
- Word completion:
  - On the edge that makes bit_cnt == WIDTH: out <= completed word and out_valid=1 for exactly one cycle; bit_cnt<=0.
  - Reception continues in SAMPLE_A. Back-to-back words need no gap.
- Latency:
  - out_valid is asserted from the 3rd clk edge after the edge that first samples in1's final mid-bit transition.
  - 2 of those edges are the synchronizer; the 3rd is the registered decode.
- Jitter tolerance: edges may arrive up to ±(HALF/2 - 1) cycles from nominal; the decoder re-anchors on every mid-bit edge.
- en low: at the next edge go to IDLE and clear shift/bit_cnt. No err, no out_valid. out holds its value.
- IDLE after an error with the line high: no restart until s has been seen low and then rises.
- out_valid and err are never high in the same cycle.
- Counter width: ceil(log2(5*HALF/2 + 1)). bit_cnt width: ceil(log2(WIDTH + 1)).

Test Plan:
- Reset: rst high for 2 cycles mid-frame, then low with the line held low -> out=0, out_valid=0, err=0, busy=0. No output until a fresh start bit arrives.
- Single word: HALF=4, start bit then 0xA5 MSB first, line low afterwards -> exactly one out_valid pulse, out=8'hA5, err never high, busy drops 2*HALF..3*HALF cycles after the last bit.
- Back-to-back words: start bit, then 0x00 then 0xFF with no gap -> two out_valid pulses 64 clk apart, out=8'h00 then 8'hFF, err=0.
- Code violation: start bit, data bits 1,0,1, then line held high for 3 half-bits -> single err pulse, no out_valid, busy=0 afterwards, out unchanged.
- Jitter: 0x3C sent with alternate mid-bit edges shifted +1 and -1 clk -> out=8'h3C, one out_valid, err=0.
- Enable abort: en dropped after 4 data bits of 0x81 and raised 20 cycles later, with the line kept toggling until en is raised and then returned low -> no out_valid, no err. A subsequent clean frame 0x81 decodes correctly.
